// File: rtl/add_rr_arb.sv
// add_rr_arb
// Round-robin arbiter that funnels NREQ requesters into one shared 64-bit adder
// and routes each in-order result back to the requester that issued it.
//
// Ports
//   ck, rst                      clock (rising edge) and asynchronous active-high reset
//   i_req_vld / o_req_rdy        per-requester handshake; o_req_rdy is a one-hot grant
//   i_req_a, i_req_b             packed operands, port k in bits [64k+63:64k]
//   i_req_htId                   packed thread ids, port k in bits [9k+8:9k]
//   o_add_vld/_a/_b/_htId        registered issue toward the adder wrapper
//   i_add_rdy                    adder wrapper can accept an issue this cycle
//   i_res_vld/i_res/i_res_htId   in-order adder result
//   o_res_vld/o_res/o_res_htId   result routed back (o_res_vld one-hot by requester)
//   o_outstanding                issued adds not yet returned
//   o_err                        sticky flag: a result arrived with nothing outstanding
module add_rr_arb #(
   parameter int NREQ      = 4,
   parameter int TAG_DEPTH = 64
) (
   input  logic                 ck,
   input  logic                 rst,
   input  logic [NREQ-1:0]      i_req_vld,
   input  logic [64*NREQ-1:0]   i_req_a,
   input  logic [64*NREQ-1:0]   i_req_b,
   input  logic [9*NREQ-1:0]    i_req_htId,
   output logic [NREQ-1:0]      o_req_rdy,
   output logic                 o_add_vld,
   output logic [63:0]          o_add_a,
   output logic [63:0]          o_add_b,
   output logic [8:0]           o_add_htId,
   input  logic                 i_add_rdy,
   input  logic                 i_res_vld,
   input  logic [63:0]          i_res,
   input  logic [8:0]           i_res_htId,
   output logic [NREQ-1:0]      o_res_vld,
   output logic [63:0]          o_res,
   output logic [8:0]           o_res_htId,
   output logic [6:0]           o_outstanding,
   output logic                 o_err
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam logic [6:0] DEPTH_CNT = 7'(TAG_DEPTH);

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [6:0]       outstanding_q, outstanding_d;
   logic             err_q, err_d;

   logic             add_vld_q;
   logic [63:0]      add_a_q, add_b_q;
   logic [8:0]       add_htId_q;

   logic [NREQ-1:0]  res_vld_q, res_vld_d;
   logic [63:0]      res_q;
   logic [8:0]       res_htId_q;

   // Tag FIFO storage: which requester each in-flight add belongs to.
   logic [IDX_W-1:0] tag_mem [TAG_DEPTH];

   // ---------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------
   logic             can_issue;
   logic             gnt_vld;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] cand;

   // Uses the count registered at the start of the cycle, so a pop in this
   // same cycle never opens a slot for a grant until the following cycle.
   assign can_issue = i_add_rdy && (outstanding_q < DEPTH_CNT);

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = rr_ptr_q;
      cand    = rr_ptr_q;
      for (int i = 0; i < NREQ; i++) begin
         cand = rr_ptr_q + IDX_W'(i);
         if (!gnt_vld && can_issue && i_req_vld[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // Grant is combinational from i_req_vld, held low while in reset.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_rdy
         assign o_req_rdy[gi] = !rst && gnt_vld && (gnt_idx == IDX_W'(gi));
      end
   endgenerate

   assign rr_ptr_d = gnt_vld ? gnt_idx + IDX_W'(1) : rr_ptr_q;

   // ---------------------------------------------------------------
   // Tag FIFO push/pop and bookkeeping
   // ---------------------------------------------------------------
   logic             push, pop;
   logic [IDX_W-1:0] pop_idx;

   assign push    = gnt_vld;
   // A result with nothing outstanding is a protocol error, never a pop.
   assign pop     = i_res_vld && (outstanding_q != 7'd0);
   // Read is combinational from the head so the one-hot return is ready one
   // cycle after the result, matching the 1-cycle return latency.
   assign pop_idx = tag_mem[rd_ptr_q];

   always_comb begin
      outstanding_d = outstanding_q;
      if (push && !pop)
         outstanding_d = outstanding_q + 7'd1;
      else if (pop && !push)
         outstanding_d = outstanding_q - 7'd1;
   end

   assign err_d = err_q || (i_res_vld && (outstanding_q == 7'd0));

   always_comb begin
      res_vld_d = '0;
      if (pop)
         res_vld_d[pop_idx] = 1'b1;
   end

   always_ff @(posedge ck) begin
      if (push)
         tag_mem[wr_ptr_q] <= gnt_idx;
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         add_vld_q     <= 1'b0;
         add_a_q       <= '0;
         add_b_q       <= '0;
         add_htId_q    <= '0;
         res_vld_q     <= '0;
         res_q         <= '0;
         res_htId_q    <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         add_vld_q     <= gnt_vld;
         res_vld_q     <= res_vld_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            res_q      <= i_res;
            res_htId_q <= i_res_htId;
         end
         // Issue payload holds its last value between grants.
         if (gnt_vld) begin
            add_a_q    <= i_req_a[64*gnt_idx +: 64];
            add_b_q    <= i_req_b[64*gnt_idx +: 64];
            add_htId_q <= i_req_htId[9*gnt_idx +: 9];
         end
      end
   end

   assign o_add_vld     = add_vld_q;
   assign o_add_a       = add_a_q;
   assign o_add_b       = add_b_q;
   assign o_add_htId    = add_htId_q;
   assign o_res_vld     = res_vld_q;
   assign o_res         = res_q;
   assign o_res_htId    = res_htId_q;
   assign o_outstanding = outstanding_q;
   assign o_err         = err_q;

endmodule

// File: tb/tb_add_rr_arb.sv
module tb_add_rr_arb;

   logic           ck = 1'b0;
   logic           rst;
   logic [3:0]     i_req_vld;
   logic [255:0]   i_req_a, i_req_b;
   logic [35:0]    i_req_htId;
   logic [3:0]     o_req_rdy;
   logic           o_add_vld;
   logic [63:0]    o_add_a, o_add_b;
   logic [8:0]     o_add_htId;
   logic           i_add_rdy;
   logic           i_res_vld;
   logic [63:0]    i_res;
   logic [8:0]     i_res_htId;
   logic [3:0]     o_res_vld;
   logic [63:0]    o_res;
   logic [8:0]     o_res_htId;
   logic [6:0]     o_outstanding;
   logic           o_err;

   int checks   = 0;
   int failures = 0;

   always #5 ck = ~ck;

   add_rr_arb #(.NREQ(4), .TAG_DEPTH(64)) dut (
      .ck(ck), .rst(rst),
      .i_req_vld(i_req_vld), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_htId(i_req_htId),
      .o_req_rdy(o_req_rdy),
      .o_add_vld(o_add_vld), .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_htId(o_add_htId),
      .i_add_rdy(i_add_rdy),
      .i_res_vld(i_res_vld), .i_res(i_res), .i_res_htId(i_res_htId),
      .o_res_vld(o_res_vld), .o_res(o_res), .o_res_htId(o_res_htId),
      .o_outstanding(o_outstanding), .o_err(o_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      i_req_vld  = 4'hF;
      i_add_rdy  = 1'b1;
      i_res_vld  = 1'b0;
      i_res      = '0;
      i_res_htId = '0;
      for (int k = 0; k < 4; k++) begin
         i_req_a[64*k +: 64]   = 64'(100 + k);
         i_req_b[64*k +: 64]   = 64'(200 + k);
         i_req_htId[9*k +: 9]  = 9'(16 + k);
      end

      // Reset state, with all requesters valid
      tick();
      chk("rst_rdy", 64'(o_req_rdy), 64'h0);
      chk("rst_add_vld", 64'(o_add_vld), 64'h0);
      chk("rst_res_vld", 64'(o_res_vld), 64'h0);
      chk("rst_out", 64'(o_outstanding), 64'h0);
      chk("rst_err", 64'(o_err), 64'h0);
      chk("rst_add_a", o_add_a, 64'h0);

      // All ports valid: grants rotate 0,1,2,3,0
      rst = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("rr_rdy%0d", c), 64'(o_req_rdy), 64'(4'b0001 << (c % 4)));
         tick();
         chk($sformatf("rr_add_vld%0d", c), 64'(o_add_vld), 64'h1);
         chk($sformatf("rr_htId%0d", c), 64'(o_add_htId), 64'(16 + c % 4));
         chk($sformatf("rr_a%0d", c), o_add_a, 64'(100 + c % 4));
      end
      chk("rr_out5", 64'(o_outstanding), 64'd5);

      // Adder not ready: no grant, no issue, pointer kept at port 1
      i_add_rdy = 1'b0;
      #1;
      chk("bp_rdy", 64'(o_req_rdy), 64'h0);
      tick();
      chk("bp_add_vld", 64'(o_add_vld), 64'h0);
      chk("bp_htId_hold", 64'(o_add_htId), 64'd16);
      i_add_rdy = 1'b1;
      #1;
      chk("bp_ptr_kept", 64'(o_req_rdy), 64'b0010);
      i_req_vld = 4'h0;
      tick();
      chk("bp_out", 64'(o_outstanding), 64'd5);

      // Reset mid-operation with 5 outstanding
      rst = 1'b1;
      #1;
      chk("mid_rst_out", 64'(o_outstanding), 64'd0);
      chk("mid_rst_add_vld", 64'(o_add_vld), 64'h0);
      tick();
      rst = 1'b0;
      i_req_vld = 4'b0101;
      #1;
      chk("mid_rst_ptr0", 64'(o_req_rdy), 64'b0001);
      i_req_vld = 4'h0;

      // Result with nothing outstanding sets the sticky error
      i_res_vld = 1'b1;
      i_res     = 64'd99;
      tick();
      i_res_vld = 1'b0;
      chk("err_set", 64'(o_err), 64'h1);
      chk("err_res_vld", 64'(o_res_vld), 64'h0);
      tick();
      tick();
      chk("err_sticky", 64'(o_err), 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("err_cleared", 64'(o_err), 64'h0);

      // Single requester on port 2 round trip
      i_req_a[128 +: 64]  = 64'd3;
      i_req_b[128 +: 64]  = 64'd4;
      i_req_htId[18 +: 9] = 9'h1A5;
      i_req_vld = 4'b0100;
      #1;
      chk("p2_rdy", 64'(o_req_rdy), 64'b0100);
      tick();
      i_req_vld = 4'h0;
      chk("p2_add_vld", 64'(o_add_vld), 64'h1);
      chk("p2_htId", 64'(o_add_htId), 64'h1A5);
      chk("p2_a", o_add_a, 64'd3);
      chk("p2_b", o_add_b, 64'd4);
      chk("p2_out", 64'(o_outstanding), 64'd1);
      i_res_vld  = 1'b1;
      i_res      = 64'd7;
      i_res_htId = 9'h1A5;
      tick();
      i_res_vld = 1'b0;
      chk("p2_res_vld", 64'(o_res_vld), 64'b0100);
      chk("p2_res", o_res, 64'd7);
      chk("p2_res_htId", 64'(o_res_htId), 64'h1A5);
      chk("p2_out0", 64'(o_outstanding), 64'd0);
      tick();
      chk("p2_res_pulse", 64'(o_res_vld), 64'h0);
      chk("p2_no_err", 64'(o_err), 64'h0);

      // Fill to 64 outstanding; pointer starts at 3 after the port-2 grant
      i_req_vld = 4'hF;
      #1;
      for (int i = 0; i < 64; i++) begin
         chk($sformatf("fill_rdy%0d", i), 64'(o_req_rdy), 64'(4'b0001 << ((3 + i) % 4)));
         tick();
      end
      chk("full_out", 64'(o_outstanding), 64'd64);
      chk("full_rdy", 64'(o_req_rdy), 64'h0);

      // Pop while full: no grant this cycle, count 64 -> 63
      i_res_vld  = 1'b1;
      i_res      = 64'd11;
      i_res_htId = 9'h013;
      tick();
      i_res_vld = 1'b0;
      chk("pop_full_out", 64'(o_outstanding), 64'd63);
      chk("pop_full_add_vld", 64'(o_add_vld), 64'h0);
      chk("pop_full_res_vld", 64'(o_res_vld), 64'b1000);
      chk("pop_full_res", o_res, 64'd11);
      #1;
      chk("regrant_rdy", 64'(o_req_rdy), 64'b1000);
      tick();
      chk("regrant_add_vld", 64'(o_add_vld), 64'h1);
      chk("regrant_out", 64'(o_outstanding), 64'd64);

      // Pop at full again, then a grant and a result in the same cycle
      i_res_vld = 1'b1;
      i_res     = 64'd12;
      #1;
      chk("pop2_rdy", 64'(o_req_rdy), 64'h0);
      tick();
      chk("pop2_res_vld", 64'(o_res_vld), 64'b0001);
      chk("pop2_out", 64'(o_outstanding), 64'd63);
      i_res = 64'd13;
      #1;
      chk("both_rdy", 64'(o_req_rdy), 64'b0001);
      tick();
      i_res_vld = 1'b0;
      chk("both_out", 64'(o_outstanding), 64'd63);
      chk("both_res_vld", 64'(o_res_vld), 64'b0010);
      chk("both_res", o_res, 64'd13);
      chk("both_add_vld", 64'(o_add_vld), 64'h1);
      chk("both_htId", 64'(o_add_htId), 64'd16);
      chk("end_err", 64'(o_err), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/add_rr_arb.md
ADD_RR_ARB -- requirements
Module: add_rr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requester ports (fixed at 4 for this release).
REQ-002 SHALL have parameter TAG_DEPTH, default 64, maximum outstanding adds (power of 2, at least 40).
REQ-003 SHALL have port ck  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_req_vld  input  NREQ  per-requester request valid.
REQ-006 SHALL have port i_req_a, i_req_b  input  64*NREQ each  operands, port k in bits [64k+63:64k].
REQ-007 SHALL have port i_req_htId  input  9*NREQ  thread id, port k in bits [9k+8:9k].
REQ-008 SHALL have port o_req_rdy  output  NREQ  one-hot grant; a transfer occurs when vld and rdy are both high for port k.
REQ-009 SHALL have ports o_add_vld (1), o_add_a (64), o_add_b (64) and o_add_htId (9), all outputs, carrying the issue toward the adder wrapper.
REQ-010 SHALL have port i_add_rdy  input  1  adder wrapper ready (almost-full based, at least 2 entries of slack).
REQ-011 SHALL have ports i_res_vld (1), i_res (64) and i_res_htId (9), all inputs, carrying the in-order adder result.
REQ-012 SHALL have ports o_res_vld (NREQ), o_res (64) and o_res_htId (9), all outputs, routing the result back to its requester.
REQ-013 SHALL have port o_outstanding  output  7  count of issued adds not yet returned.
REQ-014 SHALL have port o_err  output  1  sticky protocol error flag.

Function
REQ-015 SHALL compute can_issue = i_add_rdy AND (outstanding < TAG_DEPTH), using the count registered at the start of the cycle; a same-cycle pop SHALL NOT unblock issue.
REQ-016 SHALL assert at most one o_req_rdy bit per cycle, and only when can_issue is high and that port's vld is high; the grant is combinational from i_req_vld.
REQ-017 SHALL search round-robin from the pointer rr_ptr (2 bits) to rr_ptr+3 mod 4, picking the first valid port.
REQ-018 SHALL load rr_ptr with (granted port + 1) mod 4 after each grant, and SHALL hold rr_ptr when there is no grant.
REQ-019 SHALL register the granted operands and htId to o_add_* with o_add_vld = 1 in the following cycle (1-cycle issue latency), and SHALL drive o_add_vld = 0 otherwise; o_add_a, o_add_b and o_add_htId SHALL hold their values while o_add_vld is 0.
REQ-020 SHALL push the granted port index (2 bits) into an internal in-order tag FIFO of TAG_DEPTH entries in the grant cycle.
REQ-021 SHALL pop the tag FIFO when i_res_vld is high; the next cycle it SHALL drive o_res_vld as one-hot at the popped port, with o_res = i_res and o_res_htId = i_res_htId (1-cycle return latency).
REQ-022 SHALL allow a grant and a result in the same cycle; in that case o_outstanding is unchanged and both paths proceed.
REQ-023 SHALL handle i_res_vld while outstanding = 0 as follows: no pop, o_res_vld stays 0, o_err is set to 1 and stays set until reset.
REQ-024 SHALL update o_outstanding each cycle as +1 per grant and -1 per valid pop, never wrapping.
REQ-025 SHALL NOT apply backpressure on results; o_res_vld is a single-cycle pulse per result.

Reset
REQ-026 SHALL, while rst is high, asynchronously force: o_add_vld = 0; o_res_vld = 0; o_req_rdy = 0; rr_ptr = 0; tag FIFO empty; o_outstanding = 0; o_err = 0; o_add_a/b/htId, o_res and o_res_htId = 0.
REQ-027 SHALL discard any in-flight tags when reset is asserted mid-operation; results returned after reset SHALL be treated per REQ-023.

Verification
REQ-028 SHALL cover this scenario: all 4 ports valid continuously with i_add_rdy = 1 -> grants 0,1,2,3,0,... one per cycle, and o_add_vld is high every cycle from cycle 2.
REQ-029 SHALL cover this scenario: only port 2 valid, with htId 0x1A5, a = 3, b = 4 -> o_add_htId = 0x1A5 one cycle after the grant; i_res = 7 returned -> o_res_vld = 4'b0100, o_res = 7, o_res_htId = 0x1A5.
REQ-030 SHALL cover this scenario: i_add_rdy = 0 while all ports are valid -> o_req_rdy = 0, o_add_vld = 0 the next cycle, and rr_ptr is unchanged.
REQ-031 SHALL cover this scenario: 64 grants with no results, then a result and a request in the same cycle -> no grant in that cycle, o_outstanding goes 64 -> 63, and a grant occurs in the next cycle.
REQ-032 SHALL cover this scenario: i_res_vld pulsed after reset with nothing outstanding -> o_err = 1, o_res_vld = 0, and o_err stays high until rst.
REQ-033 SHALL cover this scenario: rst asserted with 5 outstanding -> o_outstanding = 0 immediately and the next grant goes to port 0 if it is valid.
